// File: rtl/muldiv_pkg.sv
//============================================================================
// Module      : muldiv_pkg
// Description : Shared op encodings, FSM state type and count-width helper
//               for the iterative multiply/divide unit and its controller.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package muldiv_pkg;

    // op field encoding; bit 1 selects divide, bit 0 selects signed
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Iteration counter width for a given operand width
    function automatic int count_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_if.sv
//============================================================================
// Module      : muldiv_if
// Description : Request/result bundle between the execute-stage controller
//               (master) and the multiply/divide unit (slave).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_step.sv
//============================================================================
// Module      : muldiv_step
// Description : One combinational iteration of the multiply/divide datapath.
//               Multiply: conditional add of the multiplicand, shift right.
//               Divide  : trial subtract, restore, select one quotient bit.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               div,
    input  logic [2*WIDTH-1:0] acc_in,   // mult: {partial, multiplier}; div: {0, dividend/quotient}
    input  logic [WIDTH:0]     rem_in,   // partial remainder (divide only)
    input  logic [WIDTH-1:0]   opnd,     // multiplicand or divisor
    output logic [2*WIDTH-1:0] acc_out,
    output logic [WIDTH:0]     rem_out
);
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_qbit;

    // Single shift-add or restoring-divide iteration
    always_comb begin
        w_sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);
        w_shift = {rem_in[WIDTH-1:0], acc_in[WIDTH-1]};
        w_trial = {1'b0, w_shift} - {2'b00, opnd};
        w_qbit  = ~w_trial[WIDTH+1];
        if (div) begin
            rem_out = w_qbit ? w_trial[WIDTH:0] : w_shift;
            acc_out = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-2:0], w_qbit};
        end else begin
            rem_out = rem_in;
            acc_out = {w_sum, acc_in[WIDTH-1:1]};
        end
    end
endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
//============================================================================
// Module      : muldiv_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO
//               registers. WIDTH iterations on magnitudes, then one
//               sign-fix cycle that writes HI/LO and pulses done.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,     // asynchronous, active-low
    muldiv_if.slave  bus
);
    localparam int CNT_W = count_width(WIDTH);

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_div;
    logic               r_signed;
    logic               r_rsign;
    logic               r_remsign;
    logic               r_bzero;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_is_signed;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH:0]     w_rem_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_remv;

    assign w_is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_is_div    = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
    assign w_a_mag     = (w_is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_b_mag     = (w_is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div     (r_div),
        .acc_in  (r_acc),
        .rem_in  (r_rem),
        .opnd    (r_opnd),
        .acc_out (w_acc_nxt),
        .rem_out (w_rem_nxt)
    );

    // Sign correction applied in FIX. On divide-by-zero the remainder
    // register holds |a|, so the normal remainder fix restores a itself,
    // while the quotient is forced to all ones without negation.
    always_comb begin
        w_prod = (r_signed && r_rsign) ? -r_acc : r_acc;
        w_remv = (r_signed && r_remsign) ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
        if (r_bzero)
            w_quo = '1;
        else
            w_quo = (r_signed && r_rsign) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    // Control FSM, iteration datapath registers and HI/LO ownership
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_div     <= 1'b0;
            r_signed  <= 1'b0;
            r_rsign   <= 1'b0;
            r_remsign <= 1'b0;
            r_bzero   <= 1'b0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_div     <= w_is_div;
                        r_signed  <= w_is_signed;
                        r_rsign   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        r_remsign <= bus.a[WIDTH-1];
                        r_bzero   <= (bus.b == '0);
                        r_rem     <= '0;
                        r_count   <= '0;
                        // multiply: multiplier in the low half, multiplicand held apart
                        // divide  : dividend in the low half, divisor held apart
                        r_acc     <= {{WIDTH{1'b0}}, w_is_div ? w_a_mag : w_b_mag};
                        r_opnd    <= w_is_div ? w_b_mag : w_a_mag;
                        r_state   <= CALC;
                    end else begin
                        if (bus.hi_we) r_hi <= bus.wdata;
                        if (bus.lo_we) r_lo <= bus.wdata;
                    end
                end
                CALC: begin
                    r_acc <= w_acc_nxt;
                    r_rem <= w_rem_nxt;
                    if (r_count == CNT_W'(WIDTH - 1))
                        r_state <= FIX;
                    else
                        r_count <= r_count + 1'b1;
                end
                FIX: begin
                    if (r_div) begin
                        r_lo <= w_quo;
                        r_hi <= w_remv;
                    end else begin
                        r_lo <= w_prod[WIDTH-1:0];
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    end
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire
